// File: rtl/ats_timer_array.sv
// ats_timer_array: NUM_CLOCKS prescaled counters and NUM_ALARMS alarm/timer slots
// behind a single valid/ready command port with a one-cycle Ack/Nack response.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_data opcode in [31:29]
//   rsp_valid/rsp_ack      one-cycle response strobe, 1=Ack 0=Nack
//   alarm_pulse            per-alarm fire pulse, PULSE_LEN cycles long
//   alarm_pending          sticky fire flags, cleared by pend_clr (write-1)
//   irq                    OR of alarm_pending
module ats_timer_array #(
    parameter int unsigned NUM_CLOCKS = 16,
    parameter int unsigned NUM_ALARMS = 24,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PULSE_LEN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_data,
    output logic                  rsp_valid,
    output logic                  rsp_ack,
    output logic [NUM_ALARMS-1:0] alarm_pulse,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    input  logic [NUM_ALARMS-1:0] pend_clr,
    output logic                  irq
);

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_SET_CLK = 3'b001;
    localparam logic [2:0] OP_CLK_EN  = 3'b010;
    localparam logic [2:0] OP_MODE    = 3'b011;
    localparam logic [2:0] OP_SET_ALM = 3'b101;
    localparam logic [2:0] OP_SET_TMR = 3'b110;
    localparam logic [2:0] OP_ALM_EN  = 3'b111;

    // Prescaler is three bits wide so that rate 3 yields a tick every 8th cycle.
    logic [2:0]            pre;
    logic                  active, clk_lock, alm_lock;
    logic [CNT_W-1:0]      cnt     [NUM_CLOCKS];
    logic [1:0]            rate    [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] clk_en;
    logic [NUM_ALARMS-1:0] alm_en, alm_rep;
    logic [3:0]            alm_clk [NUM_ALARMS];
    logic [CNT_W-1:0]      alm_val [NUM_ALARMS];
    logic [3:0]            pcnt    [NUM_ALARMS];

    // Command field decode
    logic [2:0]       op;
    logic [3:0]       c_idx, ref_clk;
    logic [4:0]       a_idx;
    logic [CNT_W-1:0] cmd_val, ref_cnt;
    logic             c_idx_ok, a_idx_ok, ref_ok, cmd_ok, cmd_acc, cmd_do;
    logic             unused_cmd_bits;

    assign op       = cmd_data[31:29];
    assign c_idx    = cmd_data[28:25];
    assign a_idx    = cmd_data[28:24];
    assign ref_clk  = cmd_data[19:16];
    assign cmd_val  = cmd_data[CNT_W-1:0];
    assign c_idx_ok = ({1'b0, c_idx} < 5'(NUM_CLOCKS));
    assign a_idx_ok = ({1'b0, a_idx} < 6'(NUM_ALARMS));
    assign ref_ok   = ({1'b0, ref_clk} < 5'(NUM_CLOCKS));
    assign cmd_acc  = cmd_valid && cmd_ready;
    assign cmd_do   = cmd_acc && cmd_ok;
    assign unused_cmd_bits = ^cmd_data;

    // Ack/Nack decision
    always_comb begin
        cmd_ok = 1'b0;
        case (op)
            OP_NOP, OP_MODE:       cmd_ok = 1'b1;
            OP_SET_CLK, OP_CLK_EN: cmd_ok = c_idx_ok && !clk_lock;
            OP_SET_ALM:            cmd_ok = a_idx_ok && ref_ok && !alm_lock;
            OP_SET_TMR:            cmd_ok = a_idx_ok && ref_ok && !alm_lock && (cmd_val != '0);
            OP_ALM_EN:             cmd_ok = a_idx_ok && !alm_lock;
            default:               cmd_ok = 1'b0;
        endcase
    end

    // Count of the clock referenced by a set-timer command (pre-update value)
    always_comb begin
        ref_cnt = '0;
        for (int c = 0; c < NUM_CLOCKS; c++)
            if (ref_clk == 4'(c)) ref_cnt = cnt[c];
    end

    // Per-rate ticks and per-clock step/load strobes
    logic [3:0]            tick;
    logic [NUM_CLOCKS-1:0] clk_step, clk_set, clk_wen;

    assign tick = {&pre, &pre[1:0], pre[0], 1'b1};

    always_comb begin
        clk_step = '0;
        clk_set  = '0;
        clk_wen  = '0;
        for (int c = 0; c < NUM_CLOCKS; c++) begin
            clk_step[c] = active && clk_en[c] && tick[rate[c]];
            clk_set[c]  = cmd_do && (op == OP_SET_CLK) && (c_idx == 4'(c));
            clk_wen[c]  = cmd_do && (op == OP_CLK_EN) && (c_idx == 4'(c));
        end
    end

    // Alarm fire detection; a command to the alarm or a load of its clock suppresses it
    logic [NUM_ALARMS-1:0] alm_wr, fire;

    always_comb begin : fire_detect
        logic [CNT_W-1:0] sel_cnt;
        logic             sel_step, sel_set;
        alm_wr = '0;
        fire   = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            sel_cnt  = '0;
            sel_step = 1'b0;
            sel_set  = 1'b0;
            for (int c = 0; c < NUM_CLOCKS; c++) begin
                if (alm_clk[i] == 4'(c)) begin
                    sel_cnt  = cnt[c];
                    sel_step = clk_step[c];
                    sel_set  = clk_set[c];
                end
            end
            alm_wr[i] = cmd_do && (a_idx == 5'(i)) &&
                        ((op == OP_SET_ALM) || (op == OP_SET_TMR) || (op == OP_ALM_EN));
            fire[i]   = alm_en[i] && sel_step && !sel_set && !alm_wr[i] &&
                        (CNT_W'(sel_cnt + CNT_W'(1)) == alm_val[i]);
        end
    end

    // State update
    always_ff @(posedge clk) begin
        if (reset) begin
            pre           <= '0;
            active        <= 1'b1;
            clk_lock      <= 1'b0;
            alm_lock      <= 1'b0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_ack       <= 1'b0;
            clk_en        <= '0;
            alm_en        <= '0;
            alm_rep       <= '0;
            alarm_pulse   <= '0;
            alarm_pending <= '0;
            for (int c = 0; c < NUM_CLOCKS; c++) begin
                cnt[c]  <= '0;
                rate[c] <= '0;
            end
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alm_clk[i] <= '0;
                alm_val[i] <= '0;
                pcnt[i]    <= '0;
            end
        end else begin
            cmd_ready <= 1'b1;
            rsp_valid <= cmd_acc;
            rsp_ack   <= cmd_acc && cmd_ok;

            if (active) pre <= pre + 3'd1;
            if (cmd_do && (op == OP_MODE)) begin
                active   <= cmd_data[28];
                clk_lock <= cmd_data[27];
                alm_lock <= cmd_data[26];
            end

            // A load wins over the same cycle's tick
            for (int c = 0; c < NUM_CLOCKS; c++) begin
                if (clk_set[c]) begin
                    cnt[c]    <= cmd_val;
                    rate[c]   <= cmd_data[23:22];
                    clk_en[c] <= 1'b1;
                end else begin
                    if (clk_step[c]) cnt[c] <= cnt[c] + CNT_W'(1);
                    if (clk_wen[c])  clk_en[c] <= cmd_data[23];
                end
            end

            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alm_wr[i]) begin
                    // Any write to a pulsing alarm ends its pulse
                    alarm_pulse[i] <= 1'b0;
                    pcnt[i]        <= '0;
                    case (op)
                        OP_SET_ALM: begin
                            alm_en[i]  <= 1'b1;
                            alm_rep[i] <= cmd_data[23];
                            alm_clk[i] <= ref_clk;
                            alm_val[i] <= cmd_val;
                        end
                        OP_SET_TMR: begin
                            alm_en[i]  <= 1'b1;
                            alm_rep[i] <= 1'b0;
                            alm_clk[i] <= ref_clk;
                            alm_val[i] <= CNT_W'(ref_cnt + cmd_val);
                        end
                        default: alm_en[i] <= cmd_data[23];
                    endcase
                end else if (fire[i]) begin
                    alarm_pulse[i] <= 1'b1;
                    pcnt[i]        <= 4'(PULSE_LEN - 1);
                    if (!alm_rep[i]) alm_en[i] <= 1'b0;
                end else if (pcnt[i] != '0) begin
                    pcnt[i] <= pcnt[i] - 4'd1;
                end else begin
                    alarm_pulse[i] <= 1'b0;
                end

                // Set wins over a same-cycle clear
                if (fire[i])           alarm_pending[i] <= 1'b1;
                else if (pend_clr[i])  alarm_pending[i] <= 1'b0;
            end
        end
    end

    assign irq = |alarm_pending;

endmodule

// File: tb/tb_ats_timer_array.sv
// Directed self-checking bench for ats_timer_array (8 clocks, 8 alarms, 16-bit, 2-cycle pulse).
module tb_ats_timer_array;

    logic        clk, reset, cmd_valid, cmd_ready, rsp_valid, rsp_ack, irq;
    logic [31:0] cmd_data;
    logic [7:0]  alarm_pulse, alarm_pending, pend_clr;
    logic [1:0]  pre_m;
    logic        active_m;
    int          n_tests, n_fail;

    ats_timer_array #(
        .NUM_CLOCKS(8), .NUM_ALARMS(8), .CNT_W(16), .PULSE_LEN(2)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .alarm_pulse(alarm_pulse), .alarm_pending(alarm_pending),
        .pend_clr(pend_clr), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase of the free-running prescaler, used to align rate-2 loads with a tick
    always @(posedge clk) begin
        if (reset) pre_m <= 2'd0;
        else if (active_m) pre_m <= pre_m + 2'd1;
    end

    function automatic logic [31:0] w_setclk(input logic [3:0] idx, input logic [1:0] rt, input logic [15:0] v);
        return {3'b001, idx, 1'b0, rt, 6'b0, v};
    endfunction
    function automatic logic [31:0] w_clken(input logic [3:0] idx, input logic en);
        return {3'b010, idx, 1'b0, en, 7'b0, 16'b0};
    endfunction
    function automatic logic [31:0] w_mode(input logic act, input logic cl, input logic al);
        return {3'b011, act, cl, al, 26'b0};
    endfunction
    function automatic logic [31:0] w_setalm(input logic [4:0] idx, input logic rep, input logic [3:0] ck, input logic [15:0] v);
        return {3'b101, idx, rep, 3'b0, ck, v};
    endfunction
    function automatic logic [31:0] w_settmr(input logic [4:0] idx, input logic [3:0] ck, input logic [15:0] d);
        return {3'b110, idx, 1'b0, 3'b0, ck, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command for one cycle and check its response the cycle after
    task automatic send(input logic [31:0] d, input logic exp_ack, input string tag);
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 32'h0;
        chk({tag, "_rv"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_ack"}, 32'(rsp_ack), 32'(exp_ack));
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        cmd_valid = 1'b0; cmd_data = 32'h0; pend_clr = 8'h0;
        active_m = 1'b1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rv",    32'(rsp_valid), 32'd0);
        chk("rst_ack",   32'(rsp_ack),   32'd0);
        chk("rst_pulse", 32'(alarm_pulse),   32'd0);
        chk("rst_pend",  32'(alarm_pending), 32'd0);
        chk("rst_irq",   32'(irq), 32'd0);
        reset = 1'b0;
        tick_n(1);
        chk("ready", 32'(cmd_ready), 32'd1);
        chk("idle_rv", 32'(rsp_valid), 32'd0);

        // One-shot alarm on clock 0 at value 5
        send(w_setclk(4'd0, 2'd0, 16'd0), 1'b1, "t1_clk");
        send(w_setalm(5'd0, 1'b0, 4'd0, 16'd5), 1'b1, "t1_alm");
        tick_n(1);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        tick_n(2);
        chk("t1_pre_fire", 32'(alarm_pulse[0]), 32'd0);
        tick_n(1);
        chk("t1_pulse_a", 32'(alarm_pulse[0]), 32'd1);
        chk("t1_pend", 32'(alarm_pending[0]), 32'd1);
        chk("t1_irq", 32'(irq), 32'd1);
        tick_n(1);
        chk("t1_pulse_b", 32'(alarm_pulse[0]), 32'd1);
        tick_n(1);
        chk("t1_pulse_end", 32'(alarm_pulse[0]), 32'd0);
        chk("t1_pend_sticky", 32'(alarm_pending[0]), 32'd1);
        pend_clr = 8'h01;
        tick_n(1);
        pend_clr = 8'h00;
        chk("t1_clr_pend", 32'(alarm_pending[0]), 32'd0);
        chk("t1_clr_irq", 32'(irq), 32'd0);
        send(w_setclk(4'd0, 2'd0, 16'd2), 1'b1, "t1_reload");
        tick_n(3);
        chk("t1_disabled_pulse", 32'(alarm_pulse[0]), 32'd0);
        chk("t1_disabled_pend", 32'(alarm_pending[0]), 32'd0);

        // Timer on rate-2 clock 3, loaded on a tick edge (load wins, no increment)
        for (int k = 0; k < 4 && pre_m != 2'b11; k++) tick_n(1);
        send(w_setclk(4'd3, 2'd2, 16'd100), 1'b1, "t2_clk");
        send(w_settmr(5'd1, 4'd3, 16'd3), 1'b1, "t2_tmr");
        tick_n(10);
        chk("t2_early_pulse", 32'(alarm_pulse[1]), 32'd0);
        chk("t2_early_pend", 32'(alarm_pending[1]), 32'd0);
        tick_n(1);
        chk("t2_fire", 32'(alarm_pulse[1]), 32'd1);
        chk("t2_pend", 32'(alarm_pending[1]), 32'd1);
        send(w_settmr(5'd1, 4'd3, 16'd0), 1'b0, "t2_dur0");
        pend_clr = 8'h02;
        tick_n(1);
        pend_clr = 8'h00;

        // pend_clr coinciding with a fire: set wins
        send(w_setclk(4'd0, 2'd0, 16'd10), 1'b1, "t5_clk");
        send(w_setalm(5'd0, 1'b0, 4'd0, 16'd13), 1'b1, "t5_alm");
        pend_clr = 8'h01;
        tick_n(2);
        chk("t5_set_wins", 32'(alarm_pending[0]), 32'd1);
        chk("t5_pulse", 32'(alarm_pulse[0]), 32'd1);
        pend_clr = 8'h00;
        tick_n(1);
        chk("t5_pend_hold", 32'(alarm_pending[0]), 32'd1);
        pend_clr = 8'h01;
        tick_n(1);
        pend_clr = 8'h00;
        chk("t5_pend_clr", 32'(alarm_pending[0]), 32'd0);

        // Locks and Nack conditions; clock 1 frozen at 51 proves the locked load had no effect
        send(w_setclk(4'd1, 2'd0, 16'd50), 1'b1, "t4_clk");
        send(w_clken(4'd1, 1'b0), 1'b1, "t4_dis");
        send(w_mode(1'b1, 1'b1, 1'b0), 1'b1, "t4_lock");
        send(w_setclk(4'd1, 2'd0, 16'd7), 1'b0, "t4_locked_set");
        send(w_clken(4'd1, 1'b1), 1'b0, "t4_locked_en");
        send(32'h8000_0000, 1'b0, "t4_op100");
        send(w_mode(1'b1, 1'b0, 1'b1), 1'b1, "t4_alock");
        send(w_setalm(5'd3, 1'b0, 4'd1, 16'd9), 1'b0, "t4_alm_locked");
        send(w_mode(1'b1, 1'b0, 1'b0), 1'b1, "t4_unlock");
        send(w_setclk(4'd15, 2'd0, 16'd0), 1'b0, "t4_clk_idx");
        send(w_setalm(5'd8, 1'b0, 4'd1, 16'd9), 1'b0, "t4_alm_idx");
        send(w_setalm(5'd3, 1'b0, 4'd9, 16'd9), 1'b0, "t4_ref_idx");
        send(w_setalm(5'd2, 1'b0, 4'd1, 16'd52), 1'b1, "t4_alm");
        send(w_clken(4'd1, 1'b1), 1'b1, "t4_en");
        chk("t4_no_fire_yet", 32'(alarm_pulse[2]), 32'd0);
        tick_n(1);
        chk("t4_count_kept", 32'(alarm_pulse[2]), 32'd1);

        // Repeating alarm across the wrap, then its refire a full period later
        send(w_setclk(4'd2, 2'd0, 16'hFFFE), 1'b1, "t3_clk");
        send(w_setalm(5'd4, 1'b1, 4'd2, 16'h0001), 1'b1, "t3_alm");
        tick_n(1);
        chk("t3_wrap_no_fire", 32'(alarm_pulse[4]), 32'd0);
        tick_n(1);
        chk("t3_fire", 32'(alarm_pulse[4]), 32'd1);
        tick_n(65535);
        chk("t3_before_refire", 32'(alarm_pulse[4]), 32'd0);
        tick_n(1);
        chk("t3_refire", 32'(alarm_pulse[4]), 32'd1);
        chk("t3_pend", 32'(alarm_pending[4]), 32'd1);

        // Reset in the middle of a pulse
        reset = 1'b1;
        tick_n(1);
        chk("t6_rst_pulse", 32'(alarm_pulse), 32'd0);
        chk("t6_rst_pend", 32'(alarm_pending), 32'd0);
        chk("t6_rst_irq", 32'(irq), 32'd0);
        chk("t6_rst_ready", 32'(cmd_ready), 32'd0);
        chk("t6_rst_rv", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        active_m = 1'b1;
        tick_n(1);

        // active=0 freezes the counters; alarm fires only after reactivation
        send(w_setclk(4'd0, 2'd0, 16'd0), 1'b1, "t6_clk");
        send(w_setalm(5'd0, 1'b0, 4'd0, 16'd4), 1'b1, "t6_alm");
        send(w_mode(1'b0, 1'b0, 1'b0), 1'b1, "t6_freeze");
        active_m = 1'b0;
        tick_n(10);
        chk("t6_frozen_pulse", 32'(alarm_pulse[0]), 32'd0);
        chk("t6_frozen_pend", 32'(alarm_pending[0]), 32'd0);
        send(w_mode(1'b1, 1'b0, 1'b0), 1'b1, "t6_resume");
        active_m = 1'b1;
        chk("t6_resume_a", 32'(alarm_pulse[0]), 32'd0);
        tick_n(1);
        chk("t6_resume_b", 32'(alarm_pulse[0]), 32'd0);
        tick_n(1);
        chk("t6_fire", 32'(alarm_pulse[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
